sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_pkg.sv | 18 +
 rtl/rr_pick.sv | 32 +++
 rtl/sprite_rom_arbiter.sv | 141 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite ROM arbiter: FSM states,
// response tag and the default ROM size.
package sprite_pkg;

    localparam int ROM_DEPTH_DEF = 25600;
    localparam int MAX_REQ       = 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [MAX_REQ-1:0] id;
        logic               err;
    } rsp_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at
// or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        // Walk from the farthest offset so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                idx = IW'(j);
                any = 1'b1;
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with burst locking in front of a shared
// synchronous sprite ROM; responses return two cycles after grant.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 5,
    parameter int ROM_DEPTH = ROM_DEPTH_DEF,
    parameter int MAX_BURST = 16
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(ROM_DEPTH);

    state_t              state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic [IW-1:0]       gidx;
    logic                xfer;
    logic                last;
    logic                err;
    logic [ADDR_W-1:0]   g_addr;
    logic [ADDR_W-1:0]   rom_addr_q;
    rsp_tag_t            tag_q, tag_d;
    logic                unused_tag_bits;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grant is masked while reset is asserted so nothing transfers.
    always_comb begin
        req_ready = '0;
        gidx      = owner_q;
        if (Reset_n) begin
            if (state_q == IDLE) begin
                gidx = pick_idx;
                if (pick_any) req_ready = pick_gnt;
            end else if (req_valid[owner_q]) begin
                req_ready[owner_q] = 1'b1;
            end
        end
    end

    assign xfer   = |req_ready;
    assign last   = req_last[gidx];
    assign g_addr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    assign err    = {1'b0, g_addr} >= DEPTH_EXT;

    assign rom_addr = xfer ? (err ? '0 : g_addr) : rom_addr_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            owner_d = gidx;
            if (state_q == IDLE) begin
                if (!last && MAX_BURST > 1) begin
                    state_d = LOCKED;
                    cnt_d   = CNT_W'(1);
                end else begin
                    rr_ptr_d = wrap_inc(gidx);
                end
            end else if (last || cnt_q == CNT_W'(MAX_BURST - 1)) begin
                state_d  = IDLE;
                cnt_d    = '0;
                rr_ptr_d = wrap_inc(owner_q);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        tag_d                  = '0;
        tag_d.id[NUM_REQ-1:0]  = req_ready;
        tag_d.err              = xfer & err;
    end

    assign unused_tag_bits = ^tag_q.id;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            tag_q      <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr;
            tag_q      <= tag_d;
            rsp_valid  <= tag_q.id[NUM_REQ-1:0];
            rsp_err    <= tag_q.err;
            // ROM data for the tagged transfer is present this cycle.
            if (|tag_q.id[NUM_REQ-1:0] && !tag_q.err)
                rsp_data <= rom_data;
            else
                rsp_data <= '0;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a small
// synchronous ROM model and a two-deep response history.
module tb_sprite_rom_arbiter;

    logic        clk;
    logic        Reset_n;
    logic [3:0]  req_valid;
    logic [75:0] req_addr;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [18:0] rom_addr;
    logic [4:0]  rom_data;
    logic [3:0]  rsp_valid;
    logic [4:0]  rsp_data;
    logic        rsp_err;

    logic [18:0] ta [4];

    int checks;
    int failures;

    logic [3:0]  p1v, p2v;
    logic [4:0]  p1d, p2d;
    logic        p1e, p2e;
    logic [18:0] exp_ra;

    sprite_rom_arbiter u_dut (
        .Clk       (clk),
        .Reset_n   (Reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    always_comb req_addr = {ta[3], ta[2], ta[1], ta[0]};

    function automatic logic [4:0] rom_fn(input logic [18:0] a);
        return a[4:0] ^ a[9:5] ^ a[14:10] ^ {1'b0, a[18:15]};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] er);
        int          gi;
        logic [18:0] a;
        logic        e;
        logic [4:0]  d;
        gi = 0;
        e  = 1'b0;
        d  = '0;
        @(negedge clk);
        chk("ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(p2v));
        if (p2v != 4'b0) begin
            chk("rsp_data", 32'(rsp_data), 32'(p2d));
            chk("rsp_err", 32'(rsp_err), 32'(p2e));
        end
        if (er != 4'b0) begin
            for (int i = 0; i < 4; i++) if (er[i]) gi = i;
            a      = ta[gi];
            e      = (a >= 19'd25600);
            exp_ra = e ? 19'd0 : a;
            d      = e ? 5'd0 : rom_fn(a);
        end
        chk("rom_addr", 32'(rom_addr), 32'(exp_ra));
        p2v = p1v; p2d = p1d; p2e = p1e;
        p1v = er;  p1d = d;   p1e = e;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_hist();
        p1v = '0; p2v = '0; p1d = '0; p2d = '0;
        p1e = 1'b0; p2e = 1'b0; exp_ra = '0;
    endtask

    initial begin
        clk       = 1'b0;
        Reset_n   = 1'b0;
        checks    = 0;
        failures  = 0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        ta[0] = 19'd10;
        ta[1] = 19'd77;
        ta[2] = 19'd300;
        ta[3] = 19'd4000;
        clr_hist();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk);
        #1;
        Reset_n   = 1'b1;
        req_valid = 4'b0000;

        // Alternating grants between requesters 0 and 2.
        req_valid = 4'b0101;
        cyc(4'b0001);
        cyc(4'b0100);
        cyc(4'b0001);
        cyc(4'b0100);
        req_valid = 4'b0000;
        cyc(4'b0000);
        cyc(4'b0000);

        // Requester 1 holds a 3-word burst against 0 and 3.
        req_valid = 4'b0010;
        req_last  = 4'b1101;
        cyc(4'b0010);
        req_valid = 4'b1011;
        cyc(4'b0010);
        req_last  = 4'b1111;
        cyc(4'b0010);
        cyc(4'b1000);
        cyc(4'b0001);
        req_valid = 4'b0000;
        cyc(4'b0000);
        cyc(4'b0000);

        // Forced release after MAX_BURST transfers.
        req_valid = 4'b0001;
        req_last  = 4'b1110;
        cyc(4'b0001);
        req_valid = 4'b0011;
        repeat (15) cyc(4'b0001);
        cyc(4'b0010);
        cyc(4'b0001);
        req_valid = 4'b0010;
        cyc(4'b0000);
        req_valid = 4'b0011;
        req_last  = 4'b1111;
        cyc(4'b0001);
        req_valid = 4'b0000;
        cyc(4'b0000);
        cyc(4'b0000);

        // Out-of-range and last in-range address.
        ta[0]     = 19'd25600;
        req_valid = 4'b0001;
        cyc(4'b0001);
        ta[0]     = 19'd25599;
        cyc(4'b0001);
        req_valid = 4'b0000;
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0000);

        // Reset pulse during a locked burst with responses in flight.
        ta[0]     = 19'd10;
        req_valid = 4'b0100;
        req_last  = 4'b1011;
        cyc(4'b0100);
        req_valid = 4'b0101;
        cyc(4'b0100);
        Reset_n = 1'b0;
        #1;
        chk("pulse_ready", 32'(req_ready), 32'h0);
        chk("pulse_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
        clr_hist();
        req_last = 4'b1111;
        cyc(4'b0001);
        cyc(4'b0100);
        req_valid = 4'b0000;
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
